iterative_alu: RTL and testbench
================================

// Module: iterative_alu
// PURPOSE
//  Multi-cycle execute unit consuming the 4-bit Operation code produced by the ALU control decoder.
//  Single-cycle ops (logic, add/sub, compare) complete in 1 cycle; shifts iterate 1 bit per cycle.
//  Sits between decode/controller and writeback/branch logic.
//  Valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; power of 2, >= 8
//  SHAMT_W     $clog2(DATA_WIDTH)  shift-amount width (derived, not overridable)
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  reset      in   1           synchronous, active-high reset
//  op_valid   in   1           operands + Operation valid
//  op_ready   out  1           unit can accept an op (== state IDLE)
//  Operation  in   4           ALU op code (encoding below)
//  SrcA       in   DATA_WIDTH  operand A
//  SrcB       in   DATA_WIDTH  operand B; shifts use SrcB[SHAMT_W-1:0]
//  res_valid  out  1           result/flags valid (== state DONE)
//  res_ready  in   1           consumer accepts result
//  ALUResult  out  DATA_WIDTH  registered result
//  Zero       out  1           ALUResult == 0
//  IllegalOp  out  1           captured op was not a defined code
// BEHAVIOUR
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 SLL, 0101 SRL, 0111 SRA, 1100 SLT (signed), 1000 EQ.
//  Any other code: ALUResult=0, IllegalOp=1, 1-cycle latency.
//  Reset: state=IDLE, ALUResult=0, Zero=1, IllegalOp=0, res_valid=0; op_ready=1 from first cycle after reset.
//  reset mid-operation aborts any SHIFT/DONE op; result discarded, no res_valid.
//  FSM IDLE/SHIFT/DONE:
//   IDLE: op_valid && op_ready -> capture Operation, SrcA, shamt.
//    Non-shift -> compute, register, go DONE.
//    Shift with shamt!=0 -> acc=SrcA, cnt=shamt, go SHIFT.
//    Shift with shamt==0 -> ALUResult=SrcA, go DONE.
//   SHIFT: each cycle shift acc by 1 (SLL: insert 0 at LSB; SRL: 0 at MSB; SRA: replicate acc MSB); cnt--.
//    cnt==1 -> write final value to ALUResult, go DONE.
//   DONE: res_valid=1, outputs held stable; res_ready -> IDLE.
//    op_ready=0 in DONE, so at least 1 bubble between ops.
//  Latency (accept edge to res_valid high):
//   non-shift = 1 cycle; shift = 1 + shamt cycles.
//   Max = DATA_WIDTH cycles (shamt = DATA_WIDTH-1).
//  Arithmetic: ADD/SUB modulo 2^DATA_WIDTH, carry/overflow dropped.
//   SLT result = {0..,1} if $signed(A)<$signed(B).
//   EQ result = 1 if A==B else 0.
//  Inputs are sampled only on the accept edge; SrcA/SrcB/Operation changes afterwards have no effect.
//  op_valid while busy is ignored (not queued); the producer must hold it until op_ready.
//  res_ready while !res_valid is ignored.
//  Zero and IllegalOp update together with ALUResult, only on DONE entry.
// STRUCTURE
//  alu_pkg: typedef enum logic [3:0] alu_op_e (ALU_AND..ALU_EQ with codes above); state enum {IDLE,SHIFT,DONE}.
//   alu_pkg is shared with the ALU control decoder.
//  Sub-module shift_step: combinational 1-bit shift of DATA_WIDTH word, inputs dir/arith.
//  Top holds FSM, operand/acc/cnt registers, single-cycle datapath.
// TESTING
//  1. reset held 3 cycles mid-SHIFT (SRL, shamt=20) -> op_ready=1, res_valid=0, ALUResult=0, Zero=1 next cycle.
//  2. ADD 0xFFFFFFFF+1 -> res_valid 1 cycle after accept, ALUResult=0, Zero=1.
//     SUB 5-7 -> 0xFFFFFFFE, Zero=0.
//  3. SRA A=0x80000000, B=31 -> res_valid 32 cycles after accept, ALUResult=0xFFFFFFFF.
//     SRL same operands -> 0x00000001.
//  4. SLL A=0x1234, B=0x20 (shamt=0) -> 1-cycle latency, ALUResult=0x1234.
//     SLT A=-1, B=1 -> 1.
//     EQ A=B=0xA5 -> 1.
//  5. res_ready held 0 for 10 cycles in DONE -> ALUResult stable; op_valid pulses ignored.
//     res_ready=1 -> IDLE next cycle, new op accepted.
//  6. Operation=1111 -> ALUResult=0, IllegalOp=1, Zero=1.
//     Next legal op clears IllegalOp.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control decoder)
// and the execute-unit state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/iterative_alu_shift_step.sv
// Combinational single-bit shift of a word: left (dir=0) inserts 0 at LSB,
// right (dir=1) inserts 0 or, when arith=1, a copy of the MSB.
module shift_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_dir,
  input  logic                  i_arith,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic w_fill;

  assign w_fill = i_arith & i_data[DATA_WIDTH-1];
  assign o_data = i_dir ? {w_fill, i_data[DATA_WIDTH-1:1]}
                        : {i_data[DATA_WIDTH-2:0], 1'b0};

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle execute unit: single-cycle logic/arith/compare ops, shifts that
// iterate one bit per cycle, valid/ready handshake on operand and result sides.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  IllegalOp
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  alu_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_dir;
  logic                  r_arith;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_illegal;

  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_illegal;
  logic                  w_is_shift;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0] w_step;

  assign w_shamt = SrcB[SHAMT_W-1:0];

  // Shifts pass SrcA through so a zero shift amount completes in one cycle.
  always_comb begin
    w_res      = '0;
    w_illegal  = 1'b0;
    w_is_shift = 1'b0;
    case (Operation)
      ALU_AND: w_res = SrcA & SrcB;
      ALU_OR:  w_res = SrcA | SrcB;
      ALU_ADD: w_res = SrcA + SrcB;
      ALU_SUB: w_res = SrcA - SrcB;
      ALU_SLT: w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_EQ:  w_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        w_is_shift = 1'b1;
        w_res      = SrcA;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_shift_step (
    .i_data (r_acc),
    .i_dir  (r_dir),
    .i_arith(r_arith),
    .o_data (w_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_arith   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (op_valid) begin
          if (w_is_shift && (w_shamt != '0)) begin
            r_acc   <= SrcA;
            r_cnt   <= w_shamt;
            r_dir   <= (Operation != ALU_SLL);
            r_arith <= (Operation == ALU_SRA);
            r_state <= ST_SHIFT;
          end else begin
            r_result  <= w_res;
            r_zero    <= (w_res == '0);
            r_illegal <= w_illegal;
            r_state   <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result  <= w_step;
            r_zero    <= (w_step == '0);
            r_illegal <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: if (res_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready  = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign IllegalOp = r_illegal;

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: driver pushes model expectations on accept,
// monitor pops and compares on each new result and checks hold stability in DONE.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  Operation = 4'd0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        IllegalOp;

  iterative_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .res_valid(res_valid),
    .res_ready(res_ready), .ALUResult(ALUResult), .Zero(Zero), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   hold_rr = 1'b1;

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic straight from the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sh;
    sh = int'(b[4:0]);
    e.res = 32'd0; e.ill = 1'b0; e.lat = 1; e.acc_edge = 0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0100: begin e.res = a << sh; e.lat = 1 + sh; end
      4'b0101: begin e.res = a >> sh; e.lat = 1 + sh; end
      4'b0111: begin e.res = $signed(a) >>> sh; e.lat = 1 + sh; end
      4'b1100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: e.res = (a == b) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Drive an op at a negedge; op_ready is state-derived, so seeing it high at
  // a negedge means the following posedge accepts.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int t;
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; op_valid = 1'b1;
    t = 0;
    while (!op_ready && t < 200) begin @(negedge clk); t++; end
    if (!op_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: op_ready stayed 0 for %0d cycles", t);
    end else if (push) begin
      e = model(op, a, b);
      e.acc_edge = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || res_valid) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
  endtask

  // Monitor: first valid cycle pops and checks values and latency;
  // later valid cycles check the held outputs are unchanged.
  initial begin
    exp_t cur;
    bit prev_valid;
    prev_valid = 1'b0;
    cur = '{res: 32'd0, zero: 1'b1, ill: 1'b0, lat: 0, acc_edge: 0};
    forever begin
      @(negedge clk);
      if (reset) prev_valid = 1'b0;
      else if (res_valid) begin
        if (!prev_valid) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result: got 0x%08h expected no result", ALUResult);
          end else begin
            cur = q.pop_front();
            chk("result", ALUResult, cur.res);
            chk("zero", 32'(Zero), 32'(cur.zero));
            chk("illegal", 32'(IllegalOp), 32'(cur.ill));
            chk("latency", 32'(cyc - cur.acc_edge + 1), 32'(cur.lat));
          end
        end else begin
          chk("hold_result", ALUResult, cur.res);
          chk("hold_flags", {30'd0, Zero, IllegalOp}, {30'd0, cur.zero, cur.ill});
        end
        prev_valid = 1'b1;
      end else prev_valid = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!hold_rr) res_ready = ($urandom_range(3) != 0);
  end

  initial begin
    logic [3:0] illegal_codes [7];
    logic [3:0] legal_codes [9];
    logic [3:0] op;
    logic [31:0] a, b;
    int t;
    illegal_codes = '{4'd3, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    legal_codes   = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd4, 4'd5, 4'd7, 4'd12, 4'd8};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_illegal", 32'(IllegalOp), 32'd0);

    // Reset mid-shift aborts the op: nothing pushed, nothing may appear.
    issue(4'b0101, 32'hDEAD_BEEF, 32'd20, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_op_ready", 32'(op_ready), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_zero", 32'(Zero), 32'd1);
    repeat (25) @(negedge clk);
    chk("abort_no_result", 32'(res_valid), 32'd0);

    hold_rr = 1'b0;
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(4'b0110, 32'd5, 32'd7, 1'b1);
    issue(4'b0111, 32'h8000_0000, 32'd31, 1'b1);
    issue(4'b0101, 32'h8000_0000, 32'd31, 1'b1);
    issue(4'b0100, 32'h1234, 32'h20, 1'b1);
    issue(4'b1100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(4'b1000, 32'hA5, 32'hA5, 1'b1);
    issue(4'b1111, 32'h1234, 32'h5678, 1'b1);
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    issue(4'b0100, 32'h0000_0001, 32'd31, 1'b1);
    drain();

    // Backpressure: result must hold and op_valid pulses must be ignored.
    hold_rr = 1'b1;
    res_ready = 1'b0;
    issue(4'b0001, 32'h1200_0000, 32'h0000_0034, 1'b1);
    t = 0;
    while (!res_valid && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      Operation = 4'b0010; SrcA = $urandom; SrcB = $urandom;
      op_valid = i[0];
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("bp_still_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_back_to_idle", 32'(op_ready), 32'd1);
    issue(4'b0110, 32'd100, 32'd100, 1'b1);
    hold_rr = 1'b0;
    drain();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(9))
        0: op = illegal_codes[$urandom_range(6)];
        default: op = legal_codes[$urandom_range(8)];
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(7) == 0) b = a;
      if ($urandom_range(7) == 0) a = 32'd0;
      issue(op, a, b, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
